// File: rtl/weight_delta.sv
// -----------------------------------------------------------------------------
// weight_delta
//
// Back-propagates an error delta through one fully connected layer. For each
// previous-layer lane p the block forms
//    oData(p) = sum over c of reduce((W(c,p) * delta(c)) >>> (WF-1))
// one term per cycle, all NP lanes in parallel.
//
// Weights are WF-bit signed values with WF-1 fraction bits; deltas are
// WD = WI+WF bit signed values with WF fraction bits, so shifting the product
// right by WF-1 returns it to the delta format.
//
// Configuration:
//    WEIGHT_DELTA_SAT_EN  defined   -> each shifted product saturates to WD bits
//                         undefined -> each shifted product wraps to WD bits
//
// Ports:
//    iCLK, iRST                 clock, asynchronous active-low reset
//    iValid_AM_Weight           weight word valid
//    oReady_AM_Weight           weight word accepted (joined with delta)
//    iData_AM_Weight            NC*NP*WF, element (c,p) at [(c*NP+p)*WF +: WF]
//    iValid_AM_Delta            delta word valid
//    oReady_AM_Delta            delta word accepted (joined with weight)
//    iData_AM_Delta             NC*WD, element c at [c*WD +: WD]
//    oValid_BM_Delta            result valid (high while in DONE)
//    iReady_BM_Delta            downstream accepts the result
//    oData_BM_Delta             NP*WO, lane p at [p*WO +: WO]
// -----------------------------------------------------------------------------
module weight_delta #(
   parameter  int NP = 4,
   parameter  int NC = 4,
   parameter  int WI = 4,
   parameter  int WF = 4,
   localparam int WD = WI + WF,
   localparam int WO = $clog2(NC) + WI + WF
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  iValid_AM_Weight,
   output logic                  oReady_AM_Weight,
   input  logic [NC*NP*WF-1:0]   iData_AM_Weight,
   input  logic                  iValid_AM_Delta,
   output logic                  oReady_AM_Delta,
   input  logic [NC*WD-1:0]      iData_AM_Delta,
   output logic                  oValid_BM_Delta,
   input  logic                  iReady_BM_Delta,
   output logic [NP*WO-1:0]      oData_BM_Delta
);

   localparam int KW = $clog2(NC);
   // Full product width; the true product of a WF-bit and a WD-bit value fits.
   localparam int WP = WF + WD;

`ifdef WEIGHT_DELTA_SAT_EN
   localparam logic signed [WP-1:0] SAT_MAX = {{(WP-WD+1){1'b0}}, {(WD-1){1'b1}}};
   localparam logic signed [WP-1:0] SAT_MIN = {{(WP-WD+1){1'b1}}, {(WD-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } stateT;

   stateT                  state;
   stateT                  nextState;
   logic                   accept;
   logic                   lastTerm;
   logic [KW-1:0]          termIdx;
   logic [NC*NP*WF-1:0]    weightReg;
   logic [NC*WD-1:0]       deltaReg;
   logic signed [WO-1:0]   acc      [NP];

   logic signed [WD-1:0]   deltaSel;
   logic signed [WF-1:0]   weightSel [NP];
   logic signed [WP-1:0]   prod      [NP];
   logic signed [WP-1:0]   shifted   [NP];
   logic signed [WD-1:0]   term      [NP];

   // -------------------------------------------------------------------------
   // Next-state and handshake decode
   // -------------------------------------------------------------------------
   assign lastTerm = (termIdx == KW'(NC - 1));

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statement leaves a value held (no latch inferred).
   always_comb begin
      nextState       = state;
      // Reset is folded in so the ready outputs are low while iRST is held,
      // even if both valids are already asserted upstream.
      accept          = iRST && (state == IDLE) && iValid_AM_Weight && iValid_AM_Delta;
      oValid_BM_Delta = (state == DONE);
      case (state)
         IDLE:    if (accept)          nextState = ACCUM;
         ACCUM:   if (lastTerm)        nextState = DONE;
         DONE:    if (iReady_BM_Delta) nextState = IDLE;
         default:                      nextState = IDLE;
      endcase
   end

   // Both inputs are joined: neither word is taken without the other.
   assign oReady_AM_Weight = accept;
   assign oReady_AM_Delta  = accept;

   // -------------------------------------------------------------------------
   // Per-lane term for the current index k
   // -------------------------------------------------------------------------
   always_comb begin
      deltaSel = deltaReg[int'(termIdx)*WD +: WD];
      for (int p = 0; p < NP; p++) begin
         weightSel[p] = weightReg[(int'(termIdx)*NP + p)*WF +: WF];
         prod[p]      = WP'(weightSel[p]) * WP'(deltaSel);
         // Arithmetic shift: floors toward minus infinity for negative products.
         shifted[p]   = prod[p] >>> (WF - 1);
`ifdef WEIGHT_DELTA_SAT_EN
         if (shifted[p] > SAT_MAX)
            term[p] = SAT_MAX[WD-1:0];
         else if (shifted[p] < SAT_MIN)
            term[p] = SAT_MIN[WD-1:0];
         else
            term[p] = WD'(shifted[p]);
`else
         term[p] = WD'(shifted[p]);
`endif
      end
   end

   // -------------------------------------------------------------------------
   // State, counter, operand and accumulator registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state     <= IDLE;
         termIdx   <= '0;
         // NOTE: the operand words are plain registers, not a RAM, so they are
         // reset with the rest; an aborted operation leaves nothing behind.
         weightReg <= '0;
         deltaReg  <= '0;
         for (int p = 0; p < NP; p++) acc[p] <= '0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (accept) begin
                  weightReg <= iData_AM_Weight;
                  deltaReg  <= iData_AM_Delta;
                  termIdx   <= '0;
                  for (int p = 0; p < NP; p++) acc[p] <= '0;
               end
            end
            ACCUM: begin
               // WO leaves $clog2(NC) guard bits over a WD-bit term, so the
               // sum of NC terms cannot overflow.
               for (int p = 0; p < NP; p++) acc[p] <= acc[p] + WO'(term[p]);
               termIdx <= termIdx + KW'(1);
            end
            default: ;
         endcase
      end
   end

   // Accumulators are only written in ACCUM, so the result holds in DONE.
   always_comb begin
      oData_BM_Delta = '0;
      for (int p = 0; p < NP; p++) oData_BM_Delta[p*WO +: WO] = acc[p];
   end

endmodule
